// File: rtl/lsu_unit.sv
// Load/store unit: accepts one ALU-stage op at a time, issues a single
// word-aligned memory request for loads/stores, extracts and sign/zero-extends
// load data, and forwards non-memory ALU results straight to writeback.
// Optional build macro LSU_MISALIGN_CHK_EN: misaligned H/W accesses are
// aborted with an error pulse instead of being issued.
//
// state | meaning
// IDLE  | ready for a new op; pass-through results are produced from here
// REQ   | dmem_req asserted, waiting for dmem_gnt
// WAIT  | load granted, waiting for dmem_rvalid or response timeout
module lsu_unit #(
  parameter int RESP_TMO = 255
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        alu_out_vld,
  input  logic [31:0] alu_out,
  input  logic [31:0] alu_rs2_data,
  input  logic [4:0]  alu_rd,
  input  logic        alu_rd_wen,
  input  logic [3:0]  alu_LS,
  input  logic        alu_lsign,
  output logic        lsu_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        lsu_vld,
  output logic [4:0]  lsu_rd,
  output logic        lsu_rd_wen,
  output logic [31:0] lsu_wdata,
  output logic        lsu_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [7:0] TMO_C = 8'(RESP_TMO);

  state_t      state_q;
  logic        is_load_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [1:0]  addr_lo_q;
  logic [4:0]  rd_q;
  logic        rd_wen_q;
  logic [7:0]  cnt_q;

  logic        misalign;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [4:0]  shamt;
  logic [31:0] rd_shift;
  logic [31:0] load_data;

  assign lsu_ready = (state_q == IDLE);

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign = ((alu_LS[1:0] == 2'b01) && alu_out[0]) ||
                    (alu_LS[1] && (alu_out[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Byte enables and lane-replicated store data for the op presented in IDLE.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = alu_rs2_data;
    case (alu_LS[1:0])
      2'b00: begin
        be_d    = 4'b0001 << alu_out[1:0];
        wdata_d = {4{alu_rs2_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {alu_out[1], 1'b0};
        wdata_d = {2{alu_rs2_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = alu_rs2_data;
      end
    endcase
  end

  // Load data alignment and sign/zero extension from the captured access.
  always_comb begin
    shamt     = 5'd0;
    rd_shift  = 32'd0;
    load_data = 32'd0;
    case (size_q)
      2'b00:   shamt = {addr_lo_q, 3'b000};
      2'b01:   shamt = {addr_lo_q[1], 4'b0000};
      default: shamt = 5'd0;
    endcase
    rd_shift = dmem_rdata >> shamt;
    case (size_q)
      2'b00:   load_data = {{24{rd_shift[7] & sign_q}}, rd_shift[7:0]};
      2'b01:   load_data = {{16{rd_shift[15] & sign_q}}, rd_shift[15:0]};
      default: load_data = rd_shift;
    endcase
  end

  // Control FSM with registered memory and writeback outputs.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      is_load_q  <= 1'b0;
      size_q     <= 2'b00;
      sign_q     <= 1'b0;
      addr_lo_q  <= 2'b00;
      rd_q       <= 5'd0;
      rd_wen_q   <= 1'b0;
      cnt_q      <= 8'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
      lsu_vld    <= 1'b0;
      lsu_rd     <= 5'd0;
      lsu_rd_wen <= 1'b0;
      lsu_wdata  <= 32'd0;
      lsu_err    <= 1'b0;
    end else begin
      lsu_vld <= 1'b0;
      lsu_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (alu_out_vld) begin
            if (alu_LS[3] || alu_LS[2]) begin
              if (misalign) begin
                lsu_vld    <= 1'b1;
                lsu_rd     <= alu_rd;
                lsu_rd_wen <= 1'b0;
                lsu_err    <= 1'b1;
              end else begin
                state_q    <= REQ;
                is_load_q  <= alu_LS[3];
                size_q     <= alu_LS[1:0];
                sign_q     <= alu_lsign;
                addr_lo_q  <= alu_out[1:0];
                rd_q       <= alu_rd;
                rd_wen_q   <= alu_rd_wen;
                dmem_req   <= 1'b1;
                dmem_we    <= ~alu_LS[3];
                dmem_addr  <= {alu_out[31:2], 2'b00};
                dmem_be    <= be_d;
                dmem_wdata <= alu_LS[3] ? 32'd0 : wdata_d;
              end
            end else begin
              lsu_vld    <= 1'b1;
              lsu_wdata  <= alu_out;
              lsu_rd     <= alu_rd;
              lsu_rd_wen <= alu_rd_wen & (alu_rd != 5'd0);
            end
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (is_load_q) begin
              state_q <= WAIT;
              cnt_q   <= 8'd0;
            end else begin
              state_q    <= IDLE;
              lsu_vld    <= 1'b1;
              lsu_rd     <= rd_q;
              lsu_rd_wen <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            state_q    <= IDLE;
            lsu_vld    <= 1'b1;
            lsu_wdata  <= load_data;
            lsu_rd     <= rd_q;
            lsu_rd_wen <= rd_wen_q & (rd_q != 5'd0);
          end else if (cnt_q == TMO_C) begin
            state_q    <= IDLE;
            lsu_vld    <= 1'b1;
            lsu_rd     <= rd_q;
            lsu_rd_wen <= 1'b0;
            lsu_err    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed spec scenarios plus randomized
// loads/stores/ALU ops compared against an arithmetic reference model.
module tb_lsu_unit;

  localparam int TMO = 255;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        alu_out_vld;
  logic [31:0] alu_out;
  logic [31:0] alu_rs2_data;
  logic [4:0]  alu_rd;
  logic        alu_rd_wen;
  logic [3:0]  alu_LS;
  logic        alu_lsign;
  logic        lsu_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        lsu_vld;
  logic [4:0]  lsu_rd;
  logic        lsu_rd_wen;
  logic [31:0] lsu_wdata;
  logic        lsu_err;

  int n_pass = 0;
  int n_total = 0;

  lsu_unit #(.RESP_TMO(TMO)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .alu_out_vld(alu_out_vld), .alu_out(alu_out), .alu_rs2_data(alu_rs2_data),
    .alu_rd(alu_rd), .alu_rd_wen(alu_rd_wen), .alu_LS(alu_LS), .alu_lsign(alu_lsign),
    .lsu_ready(lsu_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata),
    .lsu_vld(lsu_vld), .lsu_rd(lsu_rd), .lsu_rd_wen(lsu_rd_wen),
    .lsu_wdata(lsu_wdata), .lsu_err(lsu_err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Reference model: byte count and byte offset of an access.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic int offset(input logic [31:0] addr, input logic [1:0] size);
    int a = int'(addr % 4);
    if (size == 2'b00) return a;
    if (size == 2'b01) return (a / 2) * 2;
    return 0;
  endfunction

  function automatic bit misaligned(input logic [31:0] addr, input logic [1:0] size);
`ifdef LSU_MISALIGN_CHK_EN
    int a = int'(addr % 4);
    if (size == 2'b01) return (a % 2) != 0;
    if (size[1]) return a != 0;
    return 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic sign, input logic [31:0] rdata);
    longint n = nbytes(size);
    longint off = offset(addr, size);
    longint mod = 64'sd1 <<< (8 * n);
    longint v = (longint'(rdata) / (64'sd1 <<< (8 * off))) % mod;
    if (sign && n < 4 && v >= mod / 2) v = v - mod;
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [1:0] size);
    int v = ((1 << nbytes(size)) - 1) << offset(addr, size);
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] rs2, input logic [1:0] size);
    longint w = 0;
    int n = nbytes(size);
    for (int i = 0; i < 4; i++)
      w = w + (((longint'(rs2) >> (8 * (i % n))) & 64'hFF) << (8 * i));
    return w[31:0];
  endfunction

  task automatic present(input logic [3:0] ls, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic wen, input logic sign);
    alu_out_vld = 1'b1; alu_LS = ls; alu_out = addr; alu_rs2_data = rs2;
    alu_rd = rd; alu_rd_wen = wen; alu_lsign = sign;
    tick();
    alu_out_vld = 1'b0; alu_out = $urandom; alu_rs2_data = $urandom;
    alu_rd = 5'($urandom); alu_LS = 4'($urandom);
  endtask

  task automatic check_mis_abort(input string tag);
    chk({tag, "_mis_req"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_mis_vld"}, {31'd0, lsu_vld}, 32'd1);
    chk({tag, "_mis_err"}, {31'd0, lsu_err}, 32'd1);
    chk({tag, "_mis_wen"}, {31'd0, lsu_rd_wen}, 32'd0);
    chk({tag, "_mis_rdy"}, {31'd0, lsu_ready}, 32'd1);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sign, input logic [4:0] rd, input logic wen,
                         input logic [31:0] rdata, input int gdly, input int rdly);
    present({2'b10, size}, addr, 32'd0, rd, wen, sign);
    if (misaligned(addr, size)) begin
      check_mis_abort(tag);
      return;
    end
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
    chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
    chk({tag, "_rdy"}, {31'd0, lsu_ready}, 32'd0);
    for (int i = 0; i < gdly; i++) tick();
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = ~rdata;
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    chk({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_early_rv"}, {31'd0, lsu_vld}, 32'd0);
    for (int i = 0; i < rdly; i++) tick();
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = $urandom;
    chk({tag, "_vld"}, {31'd0, lsu_vld}, 32'd1);
    chk({tag, "_data"}, lsu_wdata, exp_load(addr, size, sign, rdata));
    chk({tag, "_rd"}, {27'd0, lsu_rd}, {27'd0, rd});
    chk({tag, "_wen"}, {31'd0, lsu_rd_wen}, {31'd0, wen && rd != 5'd0});
    chk({tag, "_err"}, {31'd0, lsu_err}, 32'd0);
    chk({tag, "_rdy2"}, {31'd0, lsu_ready}, 32'd1);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] rs2, input int gdly);
    present({2'b01, size}, addr, rs2, 5'd3, 1'b1, 1'b0);
    if (misaligned(addr, size)) begin
      check_mis_abort(tag);
      return;
    end
    chk({tag, "_we"}, {31'd0, dmem_we}, 32'd1);
    chk({tag, "_be"}, {28'd0, dmem_be}, {28'd0, exp_be(addr, size)});
    chk({tag, "_wdata"}, dmem_wdata, exp_wdata(rs2, size));
    for (int i = 0; i < gdly; i++) begin
      chk({tag, "_hold_req"}, {31'd0, dmem_req}, 32'd1);
      chk({tag, "_hold_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
      chk({tag, "_hold_rdy"}, {31'd0, lsu_ready}, 32'd0);
      tick();
    end
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk({tag, "_vld"}, {31'd0, lsu_vld}, 32'd1);
    chk({tag, "_wen"}, {31'd0, lsu_rd_wen}, 32'd0);
    chk({tag, "_req_drop"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, lsu_ready}, 32'd1);
  endtask

  task automatic do_alu(input string tag, input logic [31:0] val, input logic [4:0] rd,
                        input logic wen);
    present(4'b0000, val, 32'd0, rd, wen, 1'b0);
    chk({tag, "_vld"}, {31'd0, lsu_vld}, 32'd1);
    chk({tag, "_data"}, lsu_wdata, val);
    chk({tag, "_rd"}, {27'd0, lsu_rd}, {27'd0, rd});
    chk({tag, "_wen"}, {31'd0, lsu_rd_wen}, {31'd0, wen && rd != 5'd0});
    chk({tag, "_rdy"}, {31'd0, lsu_ready}, 32'd1);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
  endtask

  logic [31:0] held;
  logic [31:0] ra;
  logic [1:0]  rs;
  int          seen;

  initial begin
    RSTN = 1'b0; alu_out_vld = 1'b0; alu_out = 32'd0; alu_rs2_data = 32'd0;
    alu_rd = 5'd0; alu_rd_wen = 1'b0; alu_LS = 4'd0; alu_lsign = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    tick(); tick();
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_vld", {31'd0, lsu_vld}, 32'd0);
    chk("rst_wdata", lsu_wdata, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_rdy", {31'd0, lsu_ready}, 32'd1);
    RSTN = 1'b1;
    tick();

    do_load("lb_neg", 32'h103, 2'b00, 1'b1, 5'd5, 1'b1, 32'h8000_0000, 0, 2);
    do_store("sh_202", 32'h202, 2'b10 - 2'b01, 32'h1234_ABCD, 3);
    do_alu("alu_rd0", 32'h55, 5'd0, 1'b1);
    tick();
    chk("alu_pulse", {31'd0, lsu_vld}, 32'd0);
    do_load("lhu", 32'h42, 2'b01, 1'b0, 5'd7, 1'b1, 32'hF00D_8001, 1, 0);
    do_load("lw", 32'h80, 2'b10, 1'b0, 5'd9, 1'b1, 32'hDEAD_BEEF, 0, 1);

    // Response timeout, then a late rvalid must be ignored.
    present(4'b1010, 32'h300, 32'd0, 5'd4, 1'b1, 1'b0);
    dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
    held = lsu_wdata;
    seen = 0;
    for (int i = 1; i <= TMO + 10; i++) begin
      tick();
      if (lsu_vld) begin seen = i; break; end
    end
    chk("tmo_latency", seen, TMO + 1);
    chk("tmo_err", {31'd0, lsu_err}, 32'd1);
    chk("tmo_wen", {31'd0, lsu_rd_wen}, 32'd0);
    chk("tmo_rdy", {31'd0, lsu_ready}, 32'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    dmem_rvalid = 1'b0;
    chk("late_rv_vld", {31'd0, lsu_vld}, 32'd0);
    chk("late_rv_err", {31'd0, lsu_err}, 32'd0);
    chk("late_rv_hold", lsu_wdata, held);

    // Misaligned word: aborted when checking is built in, otherwise a plain LW.
    do_load("lw_101", 32'h101, 2'b10, 1'b0, 5'd6, 1'b1, 32'hCAFE_F00D, 0, 0);
    tick();

    // Reset while waiting for read data.
    present(4'b1010, 32'h400, 32'd0, 5'd8, 1'b1, 1'b0);
    dmem_gnt = 1'b1; tick(); dmem_gnt = 1'b0;
    tick();
    RSTN = 1'b0; tick(); RSTN = 1'b1;
    chk("rstw_req", {31'd0, dmem_req}, 32'd0);
    chk("rstw_addr", dmem_addr, 32'd0);
    chk("rstw_wdata", lsu_wdata, 32'd0);
    chk("rstw_rd", {27'd0, lsu_rd}, 32'd0);
    chk("rstw_rdy", {31'd0, lsu_ready}, 32'd1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF; tick(); dmem_rvalid = 1'b0;
    chk("rstw_stale_rv", {31'd0, lsu_vld}, 32'd0);

    // Randomized mix.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rs = 2'($urandom);
      case ($urandom_range(0, 2))
        0: do_load("rnd_ld", ra, rs, 1'($urandom), 5'($urandom), 1'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        1: do_store("rnd_st", ra, rs, $urandom, $urandom_range(0, 3));
        default: do_alu("rnd_alu", ra, 5'($urandom), 1'($urandom));
      endcase
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 SHALL have parameter: RESP_TMO, 255, max cycles waited for dmem_rvalid on a load before abort.
REQ-002 SHALL have ports (name direction width meaning):
- CLK  in  1  sole clock, rising edge
- RSTN  in  1  reset, synchronous, active-low
- alu_out_vld  in  1  ALU stage valid
- alu_out  in  32  effective address (mem op) or ALU result
- alu_rs2_data  in  32  store data
- alu_rd  in  5  destination register
- alu_rd_wen  in  1  writeback enable
- alu_LS  in  4  {load, store, size[1:0]}; size 00=B, 01=H, 10/11=W
- alu_lsign  in  1  1=sign-extend load
- lsu_ready  out  1  LSU can accept (ALU freezes when low)
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write
- dmem_addr  out  32  word address, bits[1:0]=0
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated write data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- lsu_vld  out  1  writeback valid pulse
- lsu_rd  out  5  writeback register
- lsu_rd_wen  out  1  writeback enable
- lsu_wdata  out  32  writeback data
- lsu_err  out  1  one-cycle abort pulse (timeout or misalign)

Function
REQ-003 FSM states SHALL be IDLE, REQ, WAIT; lsu_ready SHALL equal (state==IDLE), combinational.
REQ-004 In IDLE with alu_out_vld=1: alu_LS[3]=1 -> load; else alu_LS[2]=1 -> store; else pass-through. Inputs captured only in IDLE.
REQ-005 Pass-through: next cycle lsu_vld=1, lsu_wdata=alu_out, lsu_rd=alu_rd, lsu_rd_wen=alu_rd_wen&(alu_rd!=0); stay IDLE.
REQ-006 Load/store accept: capture address, size, sign, rd, data; next state REQ; dmem_req=1 registered from the following cycle, held with stable outputs until dmem_gnt.
REQ-007 Store in REQ with dmem_gnt: state -> IDLE; lsu_vld=1, lsu_rd_wen=0 next cycle.
REQ-008 Load in REQ with dmem_gnt: state -> WAIT; dmem_req deasserts next cycle; dmem_rvalid in same cycle as dmem_gnt SHALL be ignored.
REQ-009 WAIT with dmem_rvalid: state -> IDLE; next cycle lsu_vld=1, lsu_wdata=extracted data, lsu_rd_wen=rd_wen&(rd!=0).
REQ-010 Load extract: rdata >> (8*addr[1:0]) (H uses {addr[1],0}); B/H SHALL sign-extend if lsign=1, else zero-extend; W unmodified.
REQ-011 Store lanes: B be=0001<<addr[1:0], wdata={4{rs2[7:0]}}; H be=0011<<{addr[1],0}, wdata={2{rs2[15:0]}}; W be=1111, wdata=rs2; dmem_we=1 stores, 0 loads.
REQ-012 WAIT timeout: 8-bit counter clears on WAIT entry, +1 per cycle; count==RESP_TMO without rvalid -> IDLE, lsu_vld=1, lsu_rd_wen=0, lsu_err=1 (one cycle).
REQ-013 dmem_rvalid outside WAIT SHALL be discarded with no output effect.
REQ-014 lsu_vld, lsu_err SHALL be single-cycle pulses; lsu_rd/lsu_wdata hold last value otherwise.

Reset
REQ-015 RSTN=0 at rising edge: state IDLE, counter 0, all registered outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, lsu_vld, lsu_rd, lsu_rd_wen, lsu_wdata, lsu_err); in-flight access abandoned, dmem_req low next edge.

Configuration
REQ-016 Macro LSU_MISALIGN_CHK_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 SHALL issue no dmem_req, stay IDLE, pulse lsu_vld with lsu_rd_wen=0 and lsu_err=1 next cycle.
REQ-017 Macro undefined: no check; W ignores addr[1:0], H ignores addr[0].

Verification
REQ-018 LB addr 0x103, rdata 0x80000000, lsign=1, rd=5 -> lsu_wdata=0xFFFFFF80, lsu_rd=5, lsu_rd_wen=1.
REQ-019 SH addr 0x202, rs2=0x1234ABCD, gnt after 3 cycles -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_addr=0x200 held 3 cycles, lsu_ready low until grant.
REQ-020 ALU op alu_out=0x55, rd=0 -> lsu_vld=1 next cycle, lsu_rd_wen=0.
REQ-021 LW, gnt, no rvalid for RESP_TMO cycles -> lsu_err=1, lsu_vld=1, lsu_rd_wen=0, lsu_ready=1 next cycle; late rvalid ignored.
REQ-022 LW addr 0x101 with LSU_MISALIGN_CHK_EN -> no dmem_req, lsu_err=1; RSTN=0 during WAIT -> all outputs 0 next cycle.
